// File: rtl/uc_pkg.sv
// Shared types and constants for the unit-clause arbiter engine port.
`ifndef LIT_IDX_MAX
`define LIT_IDX_MAX 127
`endif
`ifndef NUM_ENGINE
`define NUM_ENGINE 3
`endif

package uc_pkg;
    localparam int UC_LIT_W   = $clog2(`LIT_IDX_MAX) + 1;
    localparam int UC_NUM_ENG = `NUM_ENGINE;

    typedef logic signed [UC_LIT_W-1:0] lit_t;

    typedef enum logic [1:0] {
        P_IDLE,
        P_SEL,
        P_HALT
    } port_state_t;

    localparam lit_t LIT_NULL = '0;
endpackage

// File: rtl/uc_eng_port_if.sv
// Arbiter-facing and core-facing signals of one engine port.
interface uc_eng_port_if
    import uc_pkg::*;
#(
    parameter int LIT_W   = UC_LIT_W,
    parameter int NUM_ENG = UC_NUM_ENG
);
    logic [LIT_W-1:0]   uca2eng;
    logic               uca2eng_push;
    logic               eng2uca_full;
    logic [NUM_ENG-1:0] engmask;
    logic               input_mode;
    logic               conflict;
    logic [LIT_W-1:0]   eng2uca;
    logic               eng2uca_empty;
    logic               eng2uca_req;
    logic               eng2uca_grant;
    logic [LIT_W-1:0]   uc_lit;
    logic               uc_valid;
    logic               uc_pop;
    logic [LIT_W-1:0]   imp_lit;
    logic               imp_valid;
    logic               imp_ready;
    logic               overflow;
    logic               halted;

    // master: arbiter plus engine core; slave: the port itself
    modport master (
        output uca2eng, uca2eng_push, engmask, input_mode, conflict,
               eng2uca_grant, uc_pop, imp_lit, imp_valid,
        input  eng2uca_full, eng2uca, eng2uca_empty, eng2uca_req,
               uc_lit, uc_valid, imp_ready, overflow, halted
    );

    modport slave (
        input  uca2eng, uca2eng_push, engmask, input_mode, conflict,
               eng2uca_grant, uc_pop, imp_lit, imp_valid,
        output eng2uca_full, eng2uca, eng2uca_empty, eng2uca_req,
               uc_lit, uc_valid, imp_ready, overflow, halted
    );
endinterface

// File: rtl/uc_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush; DEPTH must be a power of 2.
module uc_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_rd, do_wr;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    // a pop frees the slot the same-cycle push lands in
    assign do_rd = pop & ~empty;
    assign do_wr = push & (~full | do_rd);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/uc_eng_port.sv
// Per-engine endpoint of the unit-clause arbiter: inbound broadcast FIFO,
// outbound implied-literal FIFO with dedup, mask-poll / PQ return, conflict halt.
//   state  | meaning
//   P_IDLE | waiting for this engine's mask bit (or in PQ mode)
//   P_SEL  | head already popped for the current mask assertion
//   P_HALT | conflict seen; everything flushed, absorbing until reset
module uc_eng_port
    import uc_pkg::*;
#(
    parameter int ENG_ID    = 0,
    parameter int IN_DEPTH  = 8,
    parameter int OUT_DEPTH = 8,
    parameter int LIT_W     = UC_LIT_W
) (
    input  logic         clk,
    input  logic         rst,
    uc_eng_port_if.slave bus
);
    localparam int IN_CW = $clog2(IN_DEPTH) + 1;

    port_state_t state_q, state_d;
    logic [LIT_W-1:0] last_q, last_d;
    logic             overflow_q, overflow_d;

    logic             halt, sel;
    logic             in_push, in_pop, in_full, in_empty, in_full_fifo;
    logic [LIT_W-1:0] in_dout;
    logic [IN_CW-1:0] in_count;
    logic             out_push, out_pop, out_full, out_empty;
    logic [LIT_W-1:0] out_dout;
    logic [$clog2(OUT_DEPTH):0] out_count;
    logic             imp_ready;
    logic             unused_ok;

    assign halt = (state_q == P_HALT);
    assign sel  = bus.engmask[ENG_ID];

    assign in_full  = (in_count == IN_CW'(IN_DEPTH));
    assign in_push  = bus.uca2eng_push & ~halt & (bus.uca2eng != LIT_W'(LIT_NULL));
    assign in_pop   = bus.uc_pop & ~halt;

    assign imp_ready = ~halt & (~out_full | out_pop);
    assign out_push  = bus.imp_valid & imp_ready
                     & (bus.imp_lit != LIT_W'(LIT_NULL)) & (bus.imp_lit != last_q);

    assign unused_ok = ^{in_full_fifo, out_count};

    uc_sync_fifo #(.DEPTH(IN_DEPTH), .WIDTH(LIT_W)) u_in_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_push),
        .din   (bus.uca2eng),
        .pop   (in_pop),
        .flush (bus.conflict),
        .dout  (in_dout),
        .full  (in_full_fifo),
        .empty (in_empty),
        .count (in_count)
    );

    uc_sync_fifo #(.DEPTH(OUT_DEPTH), .WIDTH(LIT_W)) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (out_push),
        .din   (bus.imp_lit),
        .pop   (out_pop),
        .flush (bus.conflict),
        .dout  (out_dout),
        .full  (out_full),
        .empty (out_empty),
        .count (out_count)
    );

    always_comb begin
        state_d = state_q;
        out_pop = 1'b0;
        case (state_q)
            P_IDLE: begin
                // the arbiter samples eng2uca in the cycle sel rises
                if (!bus.input_mode && sel) begin
                    out_pop = ~out_empty;
                    state_d = P_SEL;
                end
            end
            P_SEL: begin
                if (bus.input_mode || !sel) state_d = P_IDLE;
            end
            P_HALT: state_d = P_HALT;
            default: state_d = P_IDLE;
        endcase
        if (bus.input_mode && !halt) out_pop = bus.eng2uca_grant & ~out_empty;
        if (bus.conflict) state_d = P_HALT;
    end

    always_comb begin
        last_d     = last_q;
        overflow_d = overflow_q;
        if (bus.conflict) begin
            last_d = '0;
        end else begin
            if (out_push) last_d = bus.imp_lit;
            if (in_push && in_full && !(bus.uc_pop && !in_empty)) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= P_IDLE;
            last_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.eng2uca_full  = halt | in_full;
    assign bus.uc_lit        = in_dout;
    assign bus.uc_valid      = ~in_empty & ~halt;
    assign bus.eng2uca       = (bus.input_mode | sel) ? out_dout : '0;
    assign bus.eng2uca_empty = out_empty | halt;
    assign bus.eng2uca_req   = bus.input_mode & ~out_empty & ~halt;
    assign bus.imp_ready     = imp_ready;
    assign bus.overflow      = overflow_q;
    assign bus.halted        = halt;
endmodule

// File: tb/tb_uc_eng_port.sv
// Directed bench for uc_eng_port with a queue-based reference model checked every cycle.
module tb_uc_eng_port;
    import uc_pkg::*;

    localparam int LW    = UC_LIT_W;
    localparam int NE    = UC_NUM_ENG;
    localparam int ENG   = 2;
    localparam int IN_D  = 4;
    localparam int OUT_D = 4;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    uc_eng_port_if #(.LIT_W(LW), .NUM_ENG(NE)) b ();

    uc_eng_port #(
        .ENG_ID(ENG), .IN_DEPTH(IN_D), .OUT_DEPTH(OUT_D), .LIT_W(LW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: plain queues and the protocol rules
    lit_t inq[$];
    lit_t outq[$];
    lit_t m_last = LIT_NULL;
    bit   m_ovf  = 1'b0;
    bit   m_halt = 1'b0;
    bit   m_prev = 1'b0;

    function automatic bit m_pop_now();
        if (m_halt || outq.size() == 0) return 1'b0;
        if (b.input_mode) return b.eng2uca_grant;
        return b.engmask[ENG] && !m_prev;
    endfunction

    function automatic bit m_ready();
        return !m_halt && (outq.size() < OUT_D || m_pop_now());
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            inq.delete();
            outq.delete();
            m_last = LIT_NULL;
            m_ovf  = 1'b0;
            m_halt = 1'b0;
            m_prev = 1'b0;
        end else if (!m_halt) begin
            if (b.conflict) begin
                inq.delete();
                outq.delete();
                m_last = LIT_NULL;
                m_halt = 1'b1;
                m_prev = 1'b0;
            end else begin
                bit pop_out, rdy;
                pop_out = m_pop_now();
                rdy     = m_ready();
                if (b.uc_pop && inq.size() != 0) void'(inq.pop_front());
                if (b.uca2eng_push && lit_t'(b.uca2eng) != LIT_NULL) begin
                    if (inq.size() < IN_D) inq.push_back(lit_t'(b.uca2eng));
                    else m_ovf = 1'b1;
                end
                if (pop_out) void'(outq.pop_front());
                if (b.imp_valid && rdy && lit_t'(b.imp_lit) != LIT_NULL
                    && lit_t'(b.imp_lit) != m_last) begin
                    outq.push_back(lit_t'(b.imp_lit));
                    m_last = lit_t'(b.imp_lit);
                end
                m_prev = !b.input_mode && b.engmask[ENG];
            end
        end
    end

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        lit_t e_uc, e_out;
        @(negedge clk);
        e_uc  = (inq.size() != 0) ? inq[0] : LIT_NULL;
        e_out = (outq.size() != 0 && (b.input_mode || b.engmask[ENG])) ? outq[0] : LIT_NULL;
        chk("halted",        LW'(b.halted),        LW'(m_halt));
        chk("eng2uca_full",  LW'(b.eng2uca_full),  LW'(m_halt || inq.size() == IN_D));
        chk("uc_valid",      LW'(b.uc_valid),      LW'(inq.size() != 0));
        chk("uc_lit",        b.uc_lit,             e_uc);
        chk("eng2uca_empty", LW'(b.eng2uca_empty), LW'(outq.size() == 0));
        chk("eng2uca_req",   LW'(b.eng2uca_req),   LW'(b.input_mode && outq.size() != 0));
        chk("eng2uca",       b.eng2uca,            e_out);
        chk("imp_ready",     LW'(b.imp_ready),     LW'(m_ready()));
        chk("overflow",      LW'(b.overflow),      LW'(m_ovf));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        b.uca2eng_push  = 1'b0;
        b.uc_pop        = 1'b0;
        b.imp_valid     = 1'b0;
        b.eng2uca_grant = 1'b0;
        b.conflict      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr();
        b.input_mode = 1'b0;
        b.engmask    = '0;
        repeat (2) cyc();
        rst = 1'b0;
        #1;
    endtask

    task automatic push_in(input lit_t v);
        b.uca2eng = v; b.uca2eng_push = 1'b1;
        cyc();
        b.uca2eng_push = 1'b0;
    endtask

    task automatic push_imp(input lit_t v);
        b.imp_lit = v; b.imp_valid = 1'b1;
        cyc();
        b.imp_valid = 1'b0;
    endtask

    task automatic pop_in(input string nm, input lit_t v);
        chk(nm, b.uc_lit, v);
        b.uc_pop = 1'b1;
        cyc();
        b.uc_pop = 1'b0;
    endtask

    task automatic poll();
        b.engmask = NE'(1 << ENG);
        repeat (2) cyc();
        b.engmask = '0;
        cyc();
    endtask

    lit_t fill_v[4] = '{8'sd3, -8'sd5, 8'sd7, 8'sd9};

    initial begin
        rst = 1'b1;
        b.uca2eng = '0; b.imp_lit = '0; b.engmask = '0; b.input_mode = 1'b0;
        clr();
        repeat (3) cyc();
        rst = 1'b0;
        #1;
        chk("rst_full",     LW'(b.eng2uca_full),  LW'(0));
        chk("rst_empty",    LW'(b.eng2uca_empty), LW'(1));
        chk("rst_ready",    LW'(b.imp_ready),     LW'(1));
        chk("rst_uc_valid", LW'(b.uc_valid),      LW'(0));

        // inbound fill, overflow, drain
        for (int i = 0; i < 4; i++) begin
            chk("fill_not_full", LW'(b.eng2uca_full), LW'(0));
            push_in(fill_v[i]);
        end
        chk("fill_full", LW'(b.eng2uca_full), LW'(1));
        push_in(8'sd11);
        chk("fill_overflow", LW'(b.overflow), LW'(1));
        for (int i = 0; i < 4; i++) pop_in("fill_order", fill_v[i]);
        chk("fill_drained", LW'(b.uc_valid), LW'(0));

        // push and pop together on a full FIFO across the pointer wrap
        do_reset();
        push_in(8'sd1); push_in(8'sd2); push_in(8'sd3);
        pop_in("wrap_head1", 8'sd1);
        push_in(8'sd4); push_in(8'sd5);
        chk("wrap_full", LW'(b.eng2uca_full), LW'(1));
        b.uca2eng = 8'sd6; b.uca2eng_push = 1'b1; b.uc_pop = 1'b1;
        cyc();
        clr();
        chk("simul_full",  LW'(b.eng2uca_full), LW'(1));
        chk("simul_noovf", LW'(b.overflow),     LW'(0));
        for (int i = 3; i <= 6; i++) pop_in("wrap_order", lit_t'(i));
        chk("wrap_drained", LW'(b.uc_valid), LW'(0));

        // mask poll
        push_imp(-8'sd4);
        push_imp(8'sd6);
        chk("mask_unsel_zero", b.eng2uca, LW'(0));
        b.engmask = NE'(1 << ENG);
        #1;
        chk("mask_poll1", b.eng2uca, LW'(-8'sd4));
        cyc();
        chk("mask_one_pop", b.eng2uca, LW'(8'sd6));
        cyc();
        b.engmask = '0;
        cyc();
        b.engmask = NE'(1 << ENG);
        #1;
        chk("mask_poll2", b.eng2uca, LW'(8'sd6));
        repeat (2) cyc();
        b.engmask = '0;
        cyc();
        chk("mask_empty2", LW'(b.eng2uca_empty), LW'(1));
        poll();
        chk("mask_empty3", LW'(b.eng2uca_empty), LW'(1));

        // PQ mode
        b.input_mode = 1'b1;
        push_imp(8'sd8);
        push_imp(8'sd9);
        chk("pq_req",  LW'(b.eng2uca_req), LW'(1));
        chk("pq_head", b.eng2uca, LW'(8'sd8));
        b.eng2uca_grant = 1'b1;
        cyc();
        chk("pq_second", b.eng2uca, LW'(8'sd9));
        cyc();
        b.eng2uca_grant = 1'b0;
        #1;
        chk("pq_req_off", LW'(b.eng2uca_req), LW'(0));
        b.eng2uca_grant = 1'b1;
        cyc();
        b.eng2uca_grant = 1'b0;
        chk("pq_grant_empty", LW'(b.eng2uca_empty), LW'(1));

        // dedup and null literal
        push_imp(8'sd5); push_imp(8'sd5); push_imp(8'sd0); push_imp(-8'sd5);
        chk("dedup_head", b.eng2uca, LW'(8'sd5));
        b.eng2uca_grant = 1'b1;
        cyc();
        chk("dedup_next", b.eng2uca, LW'(-8'sd5));
        cyc();
        b.eng2uca_grant = 1'b0;
        #1;
        chk("dedup_only2", LW'(b.eng2uca_empty), LW'(1));

        // conflict mid-stream
        do_reset();
        b.uca2eng = 8'sd1; b.uca2eng_push = 1'b1; b.imp_lit = 8'sd1; b.imp_valid = 1'b1;
        cyc();
        b.uca2eng = 8'sd2; b.imp_lit = 8'sd2;
        cyc();
        b.uca2eng_push = 1'b0; b.imp_lit = 8'sd3;
        cyc();
        clr();
        b.conflict = 1'b1;
        cyc();
        b.conflict = 1'b0;
        #1;
        chk("cfl_halted",   LW'(b.halted),        LW'(1));
        chk("cfl_uc_valid", LW'(b.uc_valid),      LW'(0));
        chk("cfl_empty",    LW'(b.eng2uca_empty), LW'(1));
        chk("cfl_ready",    LW'(b.imp_ready),     LW'(0));
        b.uca2eng = 8'sd7; b.uca2eng_push = 1'b1; b.imp_lit = 8'sd4; b.imp_valid = 1'b1;
        repeat (5) cyc();
        clr();
        b.input_mode = 1'b1;
        #1;
        chk("halt_noovf", LW'(b.overflow),    LW'(0));
        chk("halt_full",  LW'(b.eng2uca_full), LW'(1));
        chk("halt_noreq", LW'(b.eng2uca_req),  LW'(0));
        do_reset();
        chk("rst2_halted", LW'(b.halted),        LW'(0));
        chk("rst2_empty",  LW'(b.eng2uca_empty), LW'(1));
        chk("rst2_ready",  LW'(b.imp_ready),     LW'(1));

        repeat (2) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
